hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 11 +
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU defines: hazard FSM state encoding and pipeline constants.
package hazard_ctrl_pkg;

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_FLUSH  = 2'd1;
    localparam logic [1:0]  ST_STALL  = 2'd2;

    localparam logic [31:0] INST_NOP  = 32'h0000_0013;
    localparam logic [31:0] ZERO_ADDR = 32'h0000_0000;

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: jump redirect/flush, load-use bubble,
// multi-cycle unit stall with sticky stall-timeout detection.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned AW            = 32,
    parameter int unsigned FLUSH_CYCLES  = 1,
    parameter int unsigned STALL_TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          jump_en_i,
    input  logic [AW-1:0] jump_addr_i,
    input  logic          load_use_i,
    input  logic          mc_busy_i,
    output logic          jump_en_o,
    output logic [AW-1:0] jump_addr_o,
    output logic          stall_pc_o,
    output logic          stall_if_id_o,
    output logic          stall_id_ex_o,
    output logic          flush_if_id_o,
    output logic          flush_id_ex_o,
    output logic          timeout_o
);

    localparam int FCW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam int BCW = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;

    localparam logic [FCW-1:0] FLUSH_INIT = FCW'(FLUSH_CYCLES);
    localparam logic [FCW-1:0] FLUSH_ONE  = FCW'(1'b1);
    localparam logic [BCW-1:0] BUSY_MAX   = BCW'(STALL_TIMEOUT);
    localparam logic [AW-1:0]  ADDR_ZERO  = AW'(ZERO_ADDR);

    logic [1:0]     state_r;
    logic [1:0]     state_nxt_s;
    logic [FCW-1:0] flush_cnt_r;
    logic [FCW-1:0] flush_cnt_nxt_s;
    logic [BCW-1:0] busy_cnt_r;
    logic [BCW-1:0] busy_cnt_nxt_s;
    logic [BCW:0]   busy_inc_s;
    logic           timeout_r;
    logic           timeout_nxt_s;

    assign busy_inc_s = {1'b0, busy_cnt_r} + {{BCW{1'b0}}, 1'b1};
    assign timeout_o  = timeout_r;

    // Output decode and next-state logic; a released STALL behaves as IDLE
    // so a jump held across the stall is taken on the first free cycle.
    always_comb begin
        jump_en_o       = 1'b0;
        jump_addr_o     = ADDR_ZERO;
        stall_pc_o      = 1'b0;
        stall_if_id_o   = 1'b0;
        stall_id_ex_o   = 1'b0;
        flush_if_id_o   = 1'b0;
        flush_id_ex_o   = 1'b0;
        state_nxt_s     = state_r;
        flush_cnt_nxt_s = flush_cnt_r;
        busy_cnt_nxt_s  = busy_cnt_r;
        timeout_nxt_s   = timeout_r;

        if (rst) begin
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
        end else if (mc_busy_i) begin
            stall_pc_o      = 1'b1;
            stall_if_id_o   = 1'b1;
            stall_id_ex_o   = 1'b1;
            state_nxt_s     = ST_STALL;
            flush_cnt_nxt_s = {FCW{1'b0}};
            if (busy_cnt_r == BUSY_MAX) begin
                busy_cnt_nxt_s = busy_cnt_r;
            end else begin
                busy_cnt_nxt_s = busy_inc_s[BCW-1:0];
            end
            if (busy_inc_s >= {1'b0, BUSY_MAX}) begin
                timeout_nxt_s = 1'b1;
            end else begin
                timeout_nxt_s = timeout_r;
            end
        end else begin
            busy_cnt_nxt_s = {BCW{1'b0}};
            case (state_r)
                ST_FLUSH: begin
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    if (flush_cnt_r <= FLUSH_ONE) begin
                        state_nxt_s     = ST_IDLE;
                        flush_cnt_nxt_s = {FCW{1'b0}};
                    end else begin
                        state_nxt_s     = ST_FLUSH;
                        flush_cnt_nxt_s = flush_cnt_r - FLUSH_ONE;
                    end
                end
                ST_IDLE, ST_STALL: begin
                    state_nxt_s = ST_IDLE;
                    if (jump_en_i) begin
                        jump_en_o     = 1'b1;
                        jump_addr_o   = jump_addr_i;
                        flush_if_id_o = 1'b1;
                        flush_id_ex_o = 1'b1;
                        if (FLUSH_CYCLES != 0) begin
                            state_nxt_s     = ST_FLUSH;
                            flush_cnt_nxt_s = FLUSH_INIT;
                        end else begin
                            state_nxt_s     = ST_IDLE;
                            flush_cnt_nxt_s = {FCW{1'b0}};
                        end
                    end else if (load_use_i) begin
                        stall_pc_o    = 1'b1;
                        stall_if_id_o = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end else begin
                        flush_cnt_nxt_s = {FCW{1'b0}};
                    end
                end
                default: begin
                    flush_if_id_o   = 1'b1;
                    flush_id_ex_o   = 1'b1;
                    state_nxt_s     = ST_IDLE;
                    flush_cnt_nxt_s = {FCW{1'b0}};
                end
            endcase
        end
    end

    // State, counters and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            flush_cnt_r <= {FCW{1'b0}};
            busy_cnt_r  <= {BCW{1'b0}};
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            flush_cnt_r <= flush_cnt_nxt_s;
            busy_cnt_r  <= busy_cnt_nxt_s;
            timeout_r   <= timeout_nxt_s;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus scoreboarded
// multi-cycle sequences (held jump over stall, timeout, reset aborts).
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        load_use_i;
    logic        mc_busy_i;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        stall_pc_o;
    logic        stall_if_id_o;
    logic        stall_id_ex_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic        timeout_o;

    int n_cmp = 0;
    int n_bad = 0;

    // out bits: {jump_en, stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, timeout}
    localparam logic [6:0] O_NONE  = 7'b000_0000;
    localparam logic [6:0] O_FLUSH = 7'b000_0110;
    localparam logic [6:0] O_JUMP  = 7'b100_0110;
    localparam logic [6:0] O_LU    = 7'b011_0010;
    localparam logic [6:0] O_STALL = 7'b011_1000;
    localparam logic [6:0] O_TO    = 7'b000_0001;

    typedef struct {
        logic        r;
        logic        je;
        logic [31:0] ja;
        logic        lu;
        logic        mb;
        logic [6:0]  eo;
        logic [31:0] ea;
    } vec_t;

    typedef struct {
        logic [6:0]  eo;
        logic [31:0] ea;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[20];

    hazard_ctrl #(
        .AW(32),
        .FLUSH_CYCLES(1),
        .STALL_TIMEOUT(64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .load_use_i   (load_use_i),
        .mc_busy_i    (mc_busy_i),
        .jump_en_o    (jump_en_o),
        .jump_addr_o  (jump_addr_o),
        .stall_pc_o   (stall_pc_o),
        .stall_if_id_o(stall_if_id_o),
        .stall_id_ex_o(stall_id_ex_o),
        .flush_if_id_o(flush_if_id_o),
        .flush_id_ex_o(flush_id_ex_o),
        .timeout_o    (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic je, input logic [31:0] ja,
                         input logic lu, input logic mb,
                         input logic [6:0] eo, input logic [31:0] ea, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        jump_en_i   = je;
        jump_addr_i = ja;
        load_use_i  = lu;
        mc_busy_i   = mb;
        e.eo  = eo;
        e.ea  = ea;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Outputs are combinational; compare mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [6:0] got;
            e   = sb_q.pop_front();
            got = {jump_en_o, stall_pc_o, stall_if_id_o, stall_id_ex_o,
                   flush_if_id_o, flush_id_ex_o, timeout_o};
            n_cmp++;
            if (got !== e.eo || jump_addr_o !== e.ea) begin
                n_bad++;
                $display("FAIL %s: got out=%b addr=%h, want out=%b addr=%h",
                         e.tag, got, jump_addr_o, e.eo, e.ea);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = 32'h0; load_use_i = 1'b0; mc_busy_i = 1'b0;

        //          r     je    ja            lu    mb    expected  addr
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, O_FLUSH, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 32'h0000_0044, 1'b1, 1'b1, O_FLUSH, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, O_NONE,  32'h0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0080, 1'b0, 1'b0, O_JUMP,  32'h80};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, O_FLUSH, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, O_NONE,  32'h0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, O_JUMP,  32'h100};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0, O_FLUSH, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, O_LU,    32'h0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, O_NONE,  32'h0};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0044, 1'b1, 1'b0, O_JUMP,  32'h44};
        vecs[11] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, O_FLUSH, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, O_NONE,  32'h0};
        vecs[13] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, O_STALL, 32'h0};
        vecs[14] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, O_LU,    32'h0};
        vecs[15] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, O_NONE,  32'h0};
        vecs[16] = '{1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b1, O_STALL, 32'h0};
        vecs[17] = '{1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0, O_JUMP,  32'h300};
        vecs[18] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, O_FLUSH, 32'h0};
        vecs[19] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, O_NONE,  32'h0};

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].r, vecs[i].je, vecs[i].ja, vecs[i].lu, vecs[i].mb,
                  vecs[i].eo, vecs[i].ea, $sformatf("tbl%0d", i));
        end

        // Busy for 10 cycles with a jump held: taken on cycle 11, then one flush cycle.
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, 1'b1, 32'h80, 1'b0, 1'b1, O_STALL, 32'h0, $sformatf("held_busy%0d", i));
        end
        drive(1'b0, 1'b1, 32'h80, 1'b0, 1'b0, O_JUMP,  32'h80, "held_jump");
        drive(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, O_FLUSH, 32'h0,  "held_flush");
        drive(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, O_NONE,  32'h0,  "held_idle");

        // 70 busy cycles: timeout visible once 64 busy cycles have completed.
        for (int k = 1; k <= 70; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, (k >= 65) ? (O_STALL | O_TO) : O_STALL,
                  32'h0, $sformatf("to_busy%0d", k));
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, O_TO, 32'h0, "to_sticky0");
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, O_LU | O_TO, 32'h0, "to_sticky1");

        // Reset mid-STALL: stalls drop, flushes rise, timeout cleared by the edge.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, O_STALL | O_TO, 32'h0, "rs_busy");
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, O_FLUSH | O_TO, 32'h0, "rs_rst0");
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, O_FLUSH, 32'h0, "rs_rst1");
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, O_NONE,  32'h0, "rs_idle");

        // Reset mid-FLUSH: the pending flush cycle is abandoned.
        drive(1'b0, 1'b1, 32'h80, 1'b0, 1'b0, O_JUMP,  32'h80, "rf_jump");
        drive(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, O_FLUSH, 32'h0,  "rf_rst");
        drive(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, O_NONE,  32'h0,  "rf_idle");
        drive(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, O_STALL, 32'h0,  "rf_busy");
        drive(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, O_NONE,  32'h0,  "rf_end");

        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
